// File: rtl/nand_gate_checker_if.sv
// Handshake and gate-bank signals between the NAND checker and its environment.
// The checker side uses the slave modport; the stimulus/gate side uses master.
interface nand_gate_checker_if #(
    parameter int NUM_GATES = 4,
    parameter int ERR_W     = 8
);
    logic                 start;
    logic [NUM_GATES-1:0] drv_a;
    logic [NUM_GATES-1:0] drv_b;
    logic [NUM_GATES-1:0] q_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] fail_mask;
    logic [ERR_W-1:0]     err_count;

    modport slave (
        input  start, q_in,
        output drv_a, drv_b, busy, done, pass, fail_mask, err_count
    );

    modport master (
        output start, q_in,
        input  drv_a, drv_b, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/nand_gate_checker.sv
// Self-test for a bank of external NAND gates: drives a one-bit-change
// vector walk, samples responses through a 2-flop synchronizer, scores them.
module nand_gate_checker #(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    nand_gate_checker_if.slave   bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SUM_W = ERR_W + $clog2(NUM_GATES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'd4;
    localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'((1 << ERR_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_GATES-1:0] r_q_s1;
    logic [NUM_GATES-1:0] r_q_sync;
    logic [NUM_GATES-1:0] r_drv_a;
    logic [NUM_GATES-1:0] r_drv_b;
    logic [NUM_GATES-1:0] r_mask;
    logic [ERR_W-1:0]     r_err;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic                 w_va;
    logic                 w_vb;
    logic                 w_exp;
    logic [NUM_GATES-1:0] w_mism;
    logic [SUM_W-1:0]     w_sum;
    logic [ERR_W-1:0]     w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.start) w_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == CNT_LAST) w_next = S_COMPARE;
            S_COMPARE: w_next = (r_idx == IDX_LAST) ? S_DONE : S_SETTLE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Vector walk 00,10,11,01,00; nothing is driven while idle
    always_comb begin
        w_va = 1'b0;
        w_vb = 1'b0;
        if (r_state != S_IDLE) begin
            case (r_idx)
                3'd1:    w_va = 1'b1;
                3'd2:    begin w_va = 1'b1; w_vb = 1'b1; end
                3'd3:    w_vb = 1'b1;
                default: ;
            endcase
        end
        w_exp = ~(w_va & w_vb);
    end

    always_comb begin
        w_mism = r_q_sync ^ {NUM_GATES{w_exp}};
        w_sum  = SUM_W'(r_err);
        for (int g = 0; g < NUM_GATES; g++) begin
            w_sum = w_sum + SUM_W'(w_mism[g]);
        end
        w_err_nxt = (w_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : w_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_q_s1   <= '0;
            r_q_sync <= '0;
            r_drv_a  <= '0;
            r_drv_b  <= '0;
            r_mask   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_q_s1   <= bus.q_in;
            r_q_sync <= r_q_s1;
            r_drv_a  <= {NUM_GATES{w_va}};
            r_drv_b  <= {NUM_GATES{w_vb}};
            r_busy   <= (r_state != S_IDLE);
            r_done   <= (r_state == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mask <= '0;
                        r_err  <= '0;
                        r_pass <= 1'b0;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + 1'b1;
                S_COMPARE: begin
                    r_mask <= r_mask | w_mism;
                    r_err  <= w_err_nxt;
                    if (r_idx != IDX_LAST) begin
                        r_idx <= r_idx + 3'd1;
                        r_cnt <= '0;
                    end
                end
                S_DONE:  r_pass <= (r_mask == '0);
                default: ;
            endcase
        end
    end

    assign bus.drv_a     = r_drv_a;
    assign bus.drv_b     = r_drv_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_mask;
    assign bus.err_count = r_err;
endmodule

// File: tb/tb_nand_gate_checker.sv
// Directed bench: models the gate bank with per-gate fault modes and
// checks vector walk, timing, scoring, saturation, abort and restart rules.
module tb_nand_gate_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    nand_gate_checker_if #(.NUM_GATES(4), .ERR_W(8)) if1 ();
    nand_gate_checker_if #(.NUM_GATES(4), .ERR_W(2)) if2 ();

    nand_gate_checker #(.NUM_GATES(4), .SETTLE_CYCLES(8), .ERR_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    nand_gate_checker #(.NUM_GATES(4), .SETTLE_CYCLES(8), .ERR_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    // 0 healthy NAND, 1 stuck-1, 2 stuck-0, 3 behaves as AND
    logic [1:0] gmode [4];
    logic [3:0] w_q;

    always_comb begin
        w_q = '0;
        for (int g = 0; g < 4; g++) begin
            case (gmode[g])
                2'd0:    w_q[g] = ~(if1.drv_a[g] & if1.drv_b[g]);
                2'd1:    w_q[g] = 1'b1;
                2'd2:    w_q[g] = 1'b0;
                default: w_q[g] = if1.drv_a[g] & if1.drv_b[g];
            endcase
        end
    end

    assign if1.q_in = w_q;
    assign if2.q_in = 4'b0000;

    logic [4:0] vec_a;
    logic [4:0] vec_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_modes(input logic [1:0] m3, input logic [1:0] m2,
                             input logic [1:0] m1, input logic [1:0] m0);
        gmode[3] = m3;
        gmode[2] = m2;
        gmode[1] = m1;
        gmode[0] = m0;
    endtask

    // Start sampled at edge k; c counts edges after k
    task automatic run(input string tag, input logic [3:0] em,
                       input logic [7:0] ee, input logic ep,
                       input int repulse, input logic hold_next);
        int early;
        early = 0;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 1; c <= 46; c++) begin
            if (c == repulse) if1.start = 1'b1;
            if (hold_next && c == 45) if1.start = 1'b1;
            tick();
            if (c == repulse) if1.start = 1'b0;
            if (c < 46 && if1.done) early++;
            if (c == 1) chk({tag, "_busy1"}, 32'(if1.busy), 32'd1);
            for (int v = 0; v < 5; v++) begin
                if (c == 5 + 9 * v)
                    chk($sformatf("%s_drv%0d", tag, v),
                        {24'd0, if1.drv_a, if1.drv_b},
                        {24'd0, {4{vec_a[v]}}, {4{vec_b[v]}}});
            end
        end
        chk({tag, "_early_done"}, 32'(early), 32'd0);
        chk({tag, "_done46"}, 32'(if1.done), 32'd1);
        chk({tag, "_busy46"}, 32'(if1.busy), 32'd1);
        chk({tag, "_pass"}, 32'(if1.pass), 32'(ep));
        chk({tag, "_mask"}, 32'(if1.fail_mask), 32'(em));
        chk({tag, "_err"}, 32'(if1.err_count), 32'(ee));
        if (!hold_next) begin
            tick();
            chk({tag, "_done_off"}, 32'(if1.done), 32'd0);
            chk({tag, "_busy_off"}, 32'(if1.busy), 32'd0);
            chk({tag, "_pass_held"}, 32'(if1.pass), 32'(ep));
            chk({tag, "_drv_idle"}, {24'd0, if1.drv_a, if1.drv_b}, 32'd0);
        end
    endtask

    initial begin
        int seen;
        int at;
        vec_a = 5'b00110;
        vec_b = 5'b01100;
        if1.start = 1'b0;
        if2.start = 1'b0;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);

        tick();
        tick();
        chk("rst_busy", 32'(if1.busy), 32'd0);
        chk("rst_done", 32'(if1.done), 32'd0);
        chk("rst_pass", 32'(if1.pass), 32'd0);
        chk("rst_mask", 32'(if1.fail_mask), 32'd0);
        chk("rst_err", 32'(if1.err_count), 32'd0);
        chk("rst_drv", {24'd0, if1.drv_a, if1.drv_b}, 32'd0);
        chk("rst_err2", 32'(if2.err_count), 32'd0);
        rst = 1'b0;
        tick();

        run("healthy", 4'b0000, 8'd0, 1'b1, 0, 1'b0);

        set_modes(2'd0, 2'd1, 2'd0, 2'd0);
        run("g2_stuck1", 4'b0100, 8'd1, 1'b0, 0, 1'b0);

        set_modes(2'd0, 2'd0, 2'd3, 2'd2);
        run("g0s0_g1and", 4'b0011, 8'd9, 1'b0, 0, 1'b0);

        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (22) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(if1.busy), 32'd0);
        chk("abort_done", 32'(if1.done), 32'd0);
        chk("abort_pass", 32'(if1.pass), 32'd0);
        chk("abort_mask", 32'(if1.fail_mask), 32'd0);
        chk("abort_err", 32'(if1.err_count), 32'd0);
        chk("abort_drv", {24'd0, if1.drv_a, if1.drv_b}, 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if1.done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run("after_abort", 4'b0000, 8'd0, 1'b1, 0, 1'b0);

        run("repulse", 4'b0000, 8'd0, 1'b1, 10, 1'b1);
        run("held", 4'b0000, 8'd0, 1'b1, 0, 1'b0);

        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        at = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (if2.done && at == 0) at = c;
        end
        chk("sat_done_at", 32'(at), 32'd46);
        chk("sat_err", 32'(if2.err_count), 32'd3);
        chk("sat_mask", 32'(if2.fail_mask), 32'hf);
        chk("sat_pass", 32'(if2.pass), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/nand_gate_checker.md
Name: nand_gate_checker

Overview:
- Synthesizable self-test block that exercises a bank of external NAND gates (one quad package by default) and checks their responses.
- Drives a fixed single-bit-change stimulus sequence onto the gate inputs and waits a settle time.
- Samples the gate outputs through a synchronizer, compares them against the NAND truth table and reports per-gate pass/fail plus a mismatch count.
- Sits between the board-level gate bank and the diagnostic/status logic, as the hardware response checker for the gate stimulus.

Parameters:
- NUM_GATES, 4, number of gates under test, one bit each in drv_a/drv_b/q_in.
- SETTLE_CYCLES, 8, cycles each vector is held before compare. Must be >= 3 (2 synchronizer stages + 1).
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test run; honoured only in IDLE.
- drv_a  out  NUM_GATES  A input to every gate.
- drv_b  out  NUM_GATES  B input to every gate.
- q_in  in  NUM_GATES  raw gate outputs (asynchronous to clk).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 if the last completed run had fail_mask==0; held until next start.
- fail_mask  out  NUM_GATES  bit g set if gate g mismatched at any vector.
- err_count  out  ERR_W  total mismatches (gate x vector), saturating.

Behaviour:
- Reset (synchronous, rst high at edge):
  - state=IDLE; drv_a=drv_b=0; busy=done=pass=0; fail_mask=0; err_count=0; vector index=0; settle counter=0; synchronizer flops=0.
  - Reset mid-run aborts immediately; no done pulse.
- q_in passes through a 2-flop synchronizer (q_sync). Compare uses q_sync only.
- Vector sequence, index 0..4, applied identically to all gates, as (a,b) -> expected q:
  - 0: (0,0)->1
  - 1: (1,0)->1
  - 2: (1,1)->0
  - 3: (0,1)->1
  - 4: (0,0)->1
  - Exactly one input changes between consecutive vectors.
- FSM:
  - IDLE: drives 0/0, busy=0. start=1 at an edge clears fail_mask, err_count and pass; sets index=0, counter=0; goes to SETTLE.
  - SETTLE: drives the current vector on all gates; counter increments each cycle; at counter==SETTLE_CYCLES-1 goes to COMPARE.
  - COMPARE: one cycle, vector still driven.
    - mism = q_sync XOR {NUM_GATES{expected}}.
    - fail_mask |= mism.
    - err_count += popcount(mism), clamped at 2^ERR_W-1.
    - If index==4 go to DONE, else index++, counter=0, go to SETTLE.
  - DONE: done=1 for exactly one cycle; pass=(fail_mask==0) becomes valid and is held; drv returns to 0 on the transition to IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - If start is sampled at edge k, done is high in the cycle beginning at edge k+1+5*(SETTLE_CYCLES+1). Default: start edge + 46.
- start while busy (SETTLE/COMPARE/DONE) is ignored; no restart, no clearing of results.
- start held continuously re-triggers a run on the first IDLE edge after DONE.
- fail_mask, err_count and pass are held after DONE until the next accepted start or rst.
- Saturation: err_count never wraps; once at max it stays there for the rest of the run.

Test Plan:
- Healthy bank (bench models q_in=~(a&b) per gate), defaults, pulse start -> drv_a/drv_b step through 00,10,11,01,00 (each held 9 cycles); done at start+46; pass=1, fail_mask=0000, err_count=0.
- Gate 2 stuck at 1 -> mismatch only on vector 2; fail_mask=0100, err_count=1, pass=0.
- Gate 0 stuck at 0 and gate 1 wired as AND -> gate 0: 4 mismatches, gate 1: 5 mismatches; fail_mask=0011, err_count=9, pass=0.
- ERR_W=2, all four gates stuck at 0 -> 16 raw mismatches; err_count saturates at 3, fail_mask=1111, pass=0.
- rst pulsed during vector 2 settle, then a fresh start with a healthy model -> no done from the aborted run; outputs 0 immediately after reset; new run completes in 46 cycles with pass=1.
- start re-pulsed at cycle 10 of a run -> ignored; done still at original start+46; single done pulse. Then start held high -> second run begins on the IDLE edge after DONE.
